// File: rtl/prefix_adder_pipe_pkg.sv
// Shared constants and the gp_cell prefix operator for the pipelined Sklansky adder.
// Flag bit positions index out_flags = {N,Z,C,V}.
package prefix_adder_pipe_pkg;

    localparam int LEN_DATA_DEF  = 32;
    localparam int LOG2_LEN_DATA = $clog2(LEN_DATA_DEF);

    localparam int NUM_FLAGS = 4;
    localparam int FLAG_N    = 3;
    localparam int FLAG_Z    = 2;
    localparam int FLAG_C    = 1;
    localparam int FLAG_V    = 0;

    // Returns {G, P} of the span formed by a high group followed by a lower group.
    function automatic logic [1:0] gp_cell(input logic g_hi, input logic p_hi,
                                           input logic g_lo, input logic p_lo);
        return {g_hi | (p_hi & g_lo), p_hi & p_lo};
    endfunction

endpackage

// File: rtl/prefix_pipe_stage.sv
// Valid/ready register slice: holds one payload, accepts whenever empty or draining.
// Payload loads only on an accepted transfer, so idle data never moves.
module prefix_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // valid/ready: a transfer happens on any rising edge where valid and ready are both high;
    // a producer holds valid and data steady until that edge.
    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined Sklansky prefix adder/subtractor with valid/ready on both sides.
// Define PREFIX_ADDER_FLAGS_EN to add the registered {N,Z,C,V} out_flags port.
module prefix_adder_pipe
    import prefix_adder_pipe_pkg::*;
#(
    parameter int          LEN_DATA  = LEN_DATA_DEF,
    parameter int unsigned PIPE_MASK = 32'b00100
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LEN_DATA-1:0] in_a,
    input  logic [LEN_DATA-1:0] in_b,
    input  logic                in_sub,
    input  logic                in_cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LEN_DATA-1:0] out_sum,
    output logic                out_cout
`ifdef PREFIX_ADDER_FLAGS_EN
    ,
    output logic [NUM_FLAGS-1:0] out_flags
`endif
);

    localparam int LOG2 = $clog2(LEN_DATA);
`ifdef PREFIX_ADDER_FLAGS_EN
    localparam int SGN_W = 2;
    localparam int SO_W  = LEN_DATA + 1 + NUM_FLAGS;
`else
    localparam int SGN_W = 0;
    localparam int SO_W  = LEN_DATA + 1;
`endif
    // Payload layout: {[sign a, sign b'], cin, p, group P, group G}
    localparam int PW     = 3 * LEN_DATA + 1 + SGN_W;
    localparam int PG_LO  = LEN_DATA;
    localparam int P_LO   = 2 * LEN_DATA;
    localparam int CIN_IX = 3 * LEN_DATA;

    logic [LEN_DATA-1:0] b_eff;
    logic                cin_eff;
    logic [PW-1:0]       s0_d;

    assign b_eff   = in_sub ? ~in_b : in_b;
    assign cin_eff = in_sub | in_cin;
`ifdef PREFIX_ADDER_FLAGS_EN
    assign s0_d = {in_a[LEN_DATA-1], b_eff[LEN_DATA-1], cin_eff,
                   in_a ^ b_eff, in_a ^ b_eff, in_a & b_eff};
`else
    assign s0_d = {cin_eff, in_a ^ b_eff, in_a ^ b_eff, in_a & b_eff};
`endif

    logic          lv_valid [LOG2+1];
    logic          lv_ready [LOG2+1];
    logic [PW-1:0] lv_data  [LOG2+1];

    prefix_pipe_stage #(.WIDTH(PW)) u_s0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (s0_d),
        .out_valid(lv_valid[0]),
        .out_ready(lv_ready[0]),
        .out_data (lv_data[0])
    );

    for (genvar k = 0; k < LOG2; k++) begin : g_level
        logic [LEN_DATA-1:0] g_n;
        logic [LEN_DATA-1:0] pg_n;
        logic [PW-1:0]       lvl_d;

        // Upper half of each 2^(k+1) block absorbs the top bit of its lower half.
        for (genvar i = 0; i < LEN_DATA; i++) begin : g_bit
            if (((i >> k) % 2) == 1) begin : g_node
                localparam int J = ((i >> k) << k) - 1;
                assign {g_n[i], pg_n[i]} = gp_cell(lv_data[k][i], lv_data[k][PG_LO+i],
                                                   lv_data[k][J], lv_data[k][PG_LO+J]);
            end else begin : g_pass
                assign g_n[i]  = lv_data[k][i];
                assign pg_n[i] = lv_data[k][PG_LO+i];
            end
        end

        assign lvl_d = {lv_data[k][PW-1:P_LO], pg_n, g_n};

        if (((PIPE_MASK >> k) & 1) == 1) begin : g_reg
            prefix_pipe_stage #(.WIDTH(PW)) u_lvl (
                .clk      (clk),
                .rst_n    (rst_n),
                .in_valid (lv_valid[k]),
                .in_ready (lv_ready[k]),
                .in_data  (lvl_d),
                .out_valid(lv_valid[k+1]),
                .out_ready(lv_ready[k+1]),
                .out_data (lv_data[k+1])
            );
        end else begin : g_wire
            assign lv_valid[k+1] = lv_valid[k];
            assign lv_ready[k]   = lv_ready[k+1];
            assign lv_data[k+1]  = lvl_d;
        end
    end

    logic [LEN_DATA-1:0] grp_g;
    logic [LEN_DATA-1:0] grp_p;
    logic [LEN_DATA-1:0] p_bit;
    logic                c_in;
    logic [LEN_DATA:0]   carry;
    logic [LEN_DATA-1:0] sum_d;
    logic [SO_W-1:0]     so_d;
    logic [SO_W-1:0]     so_q;

    assign grp_g = lv_data[LOG2][LEN_DATA-1:0];
    assign grp_p = lv_data[LOG2][PG_LO +: LEN_DATA];
    assign p_bit = lv_data[LOG2][P_LO +: LEN_DATA];
    assign c_in  = lv_data[LOG2][CIN_IX];
    // Carry-in acts as g[-1]: c[i+1] = G[i:0] | P[i:0] & cin.
    assign carry = {grp_g | (grp_p & {LEN_DATA{c_in}}), c_in};
    assign sum_d = p_bit ^ carry[LEN_DATA-1:0];

`ifdef PREFIX_ADDER_FLAGS_EN
    logic                 sgn_a;
    logic                 sgn_b;
    logic [NUM_FLAGS-1:0] flags_d;

    assign sgn_a = lv_data[LOG2][CIN_IX+2];
    assign sgn_b = lv_data[LOG2][CIN_IX+1];

    always_comb begin
        flags_d         = '0;
        flags_d[FLAG_N] = sum_d[LEN_DATA-1];
        flags_d[FLAG_Z] = (sum_d == '0);
        flags_d[FLAG_C] = carry[LEN_DATA];
        flags_d[FLAG_V] = (sgn_a == sgn_b) && (sum_d[LEN_DATA-1] != sgn_a);
    end

    assign so_d      = {flags_d, carry[LEN_DATA], sum_d};
    assign out_flags = so_q[LEN_DATA+1 +: NUM_FLAGS];
`else
    assign so_d = {carry[LEN_DATA], sum_d};
`endif

    prefix_pipe_stage #(.WIDTH(SO_W)) u_so (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (lv_valid[LOG2]),
        .in_ready (lv_ready[LOG2]),
        .in_data  (so_d),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (so_q)
    );

    assign out_sum  = so_q[LEN_DATA-1:0];
    assign out_cout = so_q[LEN_DATA];

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Bench for prefix_adder_pipe: directed corners, random streams, backpressure, bubbles,
// async reset and alternate widths/masks, checked against an arithmetic reference model.
module tb_prefix_adder_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_sub, in_cin;
    logic        out_valid, out_ready, out_cout;
    logic [31:0] in_a, in_b, out_sum;

    logic        x_valid, x_sub, x_cin;
    logic [63:0] x_a, x_b;
    logic        rdy8, vld8, cout8, rdy64, vld64, cout64;
    logic [7:0]  sum8;
    logic [63:0] sum64;
`ifdef PREFIX_ADDER_FLAGS_EN
    logic [3:0]  out_flags, flags8, flags64;
`endif

    always #5 clk = ~clk;

    prefix_adder_pipe #(.LEN_DATA(32), .PIPE_MASK(32'b00100)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout)
`ifdef PREFIX_ADDER_FLAGS_EN
        , .out_flags(out_flags)
`endif
    );

    prefix_adder_pipe #(.LEN_DATA(8), .PIPE_MASK(32'h0)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(rdy8),
        .in_a(x_a[7:0]), .in_b(x_b[7:0]), .in_sub(x_sub), .in_cin(x_cin),
        .out_valid(vld8), .out_ready(1'b1), .out_sum(sum8), .out_cout(cout8)
`ifdef PREFIX_ADDER_FLAGS_EN
        , .out_flags(flags8)
`endif
    );

    prefix_adder_pipe #(.LEN_DATA(64), .PIPE_MASK(32'h3F)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(rdy64),
        .in_a(x_a), .in_b(x_b), .in_sub(x_sub), .in_cin(x_cin),
        .out_valid(vld64), .out_ready(1'b1), .out_sum(sum64), .out_cout(cout64)
`ifdef PREFIX_ADDER_FLAGS_EN
        , .out_flags(flags64)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on n-bit operands; returns {cout, sum}.
    function automatic logic [64:0] ref_add(input int n, input logic [63:0] a, input logic [63:0] b,
                                            input logic sub, input logic cin);
        logic [63:0] m, am, bm, s;
        logic [64:0] full;
        logic        co;
        m  = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
        am = a & m;
        bm = b & m;
        if (sub) begin
            s  = (am - bm) & m;
            co = (am >= bm);
        end else begin
            full = {1'b0, am} + {1'b0, bm} + {64'd0, cin};
            s    = full[63:0] & m;
            full = full >> n;
            co   = full[0];
        end
        return {co, s};
    endfunction

    // 32-bit expectation {flags, cout, sum}; V from true signed arithmetic overflowing.
    function automatic logic [36:0] model32(input logic [31:0] a, input logic [31:0] b,
                                            input logic sub, input logic cin);
        logic [64:0] r;
        logic [31:0] s;
        logic        co;
        longint      sa, sb, t;
        logic [3:0]  f;
        r  = ref_add(32, {32'd0, a}, {32'd0, b}, sub, cin);
        s  = r[31:0];
        co = r[64];
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        t  = sub ? (sa - sb) : (sa + sb + longint'({63'd0, cin}));
        f  = {s[31], (s == 32'd0), co, (t != longint'($signed(s)))};
`ifndef PREFIX_ADDER_FLAGS_EN
        f = 4'd0;
`endif
        return {f, co, s};
    endfunction

    function automatic logic [36:0] obs32();
`ifdef PREFIX_ADDER_FLAGS_EN
        return {out_flags, out_cout, out_sum};
`else
        return {4'd0, out_cout, out_sum};
`endif
    endfunction

    // Scoreboards and monitors: sample on the falling edge, ahead of the next transfer edge.
    logic [36:0] exp_q[$];
    logic [8:0]  exp8_q[$];
    logic [64:0] exp64_q[$];
    logic        last_in_fire = 1'b0;
    logic        stall_q = 1'b0;
    logic [36:0] held;
    logic        track_gap = 1'b0;
    int          cyc = 0, last_pop = -1, n_out = 0, n_in = 0, n_gap = 0;

    always @(negedge clk) begin
        logic [36:0] e;
        cyc++;
        if (!rst_n) begin
            last_in_fire = 1'b0;
            stall_q      = 1'b0;
        end else begin
            last_in_fire = in_valid && in_ready;
            if (last_in_fire) begin
                exp_q.push_back(model32(in_a, in_b, in_sub, in_cin));
                n_in++;
            end
            if (stall_q) check("hold_stable", obs32(), held);
            if (out_valid && out_ready) begin
                check("result_expected", (exp_q.size() != 0), 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("result32", obs32(), e);
                end
                n_out++;
                if (track_gap) begin
                    if (last_pop >= 0 && (cyc - last_pop) != 1) n_gap++;
                    last_pop = cyc;
                end
            end
            stall_q = out_valid && !out_ready;
            held    = obs32();
        end
    end

    always @(negedge clk) begin
        logic [64:0] r;
        logic [8:0]  e8;
        logic [64:0] e64;
        if (rst_n) begin
            if (x_valid && rdy8) begin
                r = ref_add(8, x_a, x_b, x_sub, x_cin);
                exp8_q.push_back({r[64], r[7:0]});
            end
            if (x_valid && rdy64) exp64_q.push_back(ref_add(64, x_a, x_b, x_sub, x_cin));
            if (vld8) begin
                check("result8_expected", (exp8_q.size() != 0), 1'b1);
                if (exp8_q.size() != 0) begin
                    e8 = exp8_q.pop_front();
                    check("result8", {cout8, sum8}, e8);
                end
            end
            if (vld64) begin
                check("result64_expected", (exp64_q.size() != 0), 1'b1);
                if (exp64_q.size() != 0) begin
                    e64 = exp64_q.pop_front();
                    check("result64", {cout64, sum64}, e64);
                end
            end
        end
    end

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic cin);
        logic ok;
        ok = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_cin = cin;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("send_accepted", ok, 1'b1);
    endtask

    task automatic step(input logic want, input logic ordy);
        @(posedge clk); #1;
        if (!in_valid || last_in_fire) begin
            in_valid = want;
            in_a     = $urandom;
            in_b     = $urandom;
            in_sub   = 1'($urandom_range(0, 1));
            in_cin   = 1'($urandom_range(0, 1));
        end
        out_ready = ordy;
    endtask

    task automatic wait_out(input string tag);
        int t;
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check(tag, out_valid, 1'b1);
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, l8, l64, n0, i0;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0;
        out_ready = 1'b1; x_valid = 1'b0; x_a = '0; x_b = '0; x_sub = 1'b0; x_cin = 1'b0;

        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_sum", out_sum, 32'd0);
        check("rst_out_cout", out_cout, 1'b0);
`ifdef PREFIX_ADDER_FLAGS_EN
        check("rst_out_flags", out_flags, 4'd0);
`endif
        #21 rst_n = 1'b1;
        #1 check("rst_in_ready", in_ready, 1'b1);

        // All-ones plus one wraps to zero with carry out; default latency is 3.
        send(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency_default", lat, 3);
        check("add_wrap_sum", out_sum, 32'd0);
        check("add_wrap_cout", out_cout, 1'b1);
`ifdef PREFIX_ADDER_FLAGS_EN
        check("add_wrap_flags", out_flags, 4'b0110);
`endif
        send(32'd5, 32'd7, 1'b1, 1'b0);
        wait_out("sub_valid");
        check("sub_borrow_sum", out_sum, 32'hFFFF_FFFE);
        check("sub_borrow_cout", out_cout, 1'b0);
        send(32'h8000_0000, 32'd1, 1'b1, 1'b1);
        wait_out("subv_valid");
        check("sub_ovf_sum", out_sum, 32'h7FFF_FFFF);
        check("sub_ovf_cout", out_cout, 1'b1);
`ifdef PREFIX_ADDER_FLAGS_EN
        check("sub_ovf_flags", out_flags, 4'b0011);
`endif
        drain("drain_directed");

        // 1000 back-to-back random operations at full throughput.
        track_gap = 1'b1; last_pop = -1; n0 = n_out; i0 = n_in; n_gap = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_a     = (i % 37 == 0) ? 32'hFFFF_FFFF : $urandom;
            in_b     = (i % 41 == 0) ? 32'h0000_0001 : $urandom;
            in_sub   = 1'($urandom_range(0, 1));
            in_cin   = 1'($urandom_range(0, 1));
        end
        drain("drain_b2b");
        track_gap = 1'b0;
        check("b2b_accepts", n_in - i0, 1000);
        check("b2b_results", n_out - n0, 1000);
        check("b2b_gaps", n_gap, 0);

        // Backpressure: pipe holds exactly three entries, then input stalls.
        i0 = n_in;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        check("bp_in_ready_low", in_ready, 1'b0);
        check("bp_out_valid", out_valid, 1'b1);
        check("bp_accepted", n_in - i0, 3);
        drain("drain_bp");

        // Sparse input with toggling output ready.
        for (int i = 0; i < 60; i++) step((i % 3) == 0, 1'(i % 2));
        drain("drain_bubble");

        // Async reset between clock edges drops in-flight work.
        for (int i = 0; i < 15; i++) step(1'b1, 1'($urandom_range(0, 1)));
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_sum", out_sum, 32'd0);
        check("midrst_out_cout", out_cout, 1'b0);
        exp_q.delete();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk); #2;
        rst_n = 1'b1;
        #1 check("midrst_in_ready", in_ready, 1'b1);
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
        wait_out("post_rst_valid");
        check("post_rst_sum", out_sum, 32'h2345_678A);
        check("post_rst_cout", out_cout, 1'b0);
        drain("drain_post_rst");

        // Alternate widths: 8-bit unmasked (latency 2) and 64-bit fully masked (latency 8).
        @(posedge clk); #1;
        x_valid = 1'b1; x_a = 64'hFFFF_FFFF_FFFF_FFFF; x_b = 64'd1; x_sub = 1'b0; x_cin = 1'b0;
        @(posedge clk); #1;
        x_valid = 1'b0;
        lat = 1; l8 = 0; l64 = 0;
        while (!(l8 != 0 && l64 != 0) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (vld8 && l8 == 0) l8 = lat;
            if (vld64 && l64 == 0) l64 = lat;
        end
        check("latency_w8_mask0", l8, 2);
        check("latency_w64_maskall", l64, 8);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            x_valid = 1'($urandom_range(0, 1));
            x_a     = {$urandom, $urandom};
            x_b     = (i % 23 == 0) ? x_a : {$urandom, $urandom};
            x_sub   = 1'($urandom_range(0, 1));
            x_cin   = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        x_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("drain_w8", exp8_q.size(), 0);
        check("drain_w64", exp64_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
